// File: rtl/spin_readout_pkg.sv
// Shared definitions for the spin readout block: FSM encoding, rdata layout
// and the legal spin-count range.
package spin_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int RDATA_WIDTH = 32;
    localparam int DONE_BIT    = 31;
    localparam int BUSY_BIT    = 30;
    localparam int MAX_SPINS   = 30;

    // Spins must fit below the two status bits of rdata.
    function automatic bit spins_in_range(input int num_spins);
        return (num_spins >= 1) && (num_spins <= MAX_SPINS);
    endfunction

endpackage

// File: rtl/spin_readout_if.sv
// Control/status bundle between the AXI register side and the spin readout core.
interface spin_readout_if #(
    parameter int NUM_SPINS = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic [CNT_WIDTH-1:0] window;
    logic                 busy;
    logic                 done;
    logic [NUM_SPINS-1:0] spins;
    logic [31:0]          rdata;

    modport master (
        output start, window,
        input  busy, done, spins, rdata
    );

    modport slave (
        input  start, window,
        output busy, done, spins, rdata
    );
endinterface

// File: rtl/spin_readout_sync.sv
// Single-bit multi-flop synchroniser for the asynchronous oscillator taps.
module spin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE", dont_touch = "true" *)
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // NOTE: flops use non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spin_readout.sv
// Counts phase mismatches of each oscillator tap against the reference over a
// programmable window and majority-votes the counts into a spin vector.
module spin_readout
    import spin_readout_pkg::*;
#(
    parameter int NUM_SPINS   = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 axi_rstn,
    input  logic [NUM_SPINS-1:0] osc_in,
    input  logic                 ref_in,
    spin_readout_if.slave        bus
);

    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    if (!spins_in_range(NUM_SPINS) || (SYNC_STAGES < 2)) begin : g_param_check
        $error("spin_readout: NUM_SPINS must be 1..30 and SYNC_STAGES >= 2");
    end

    logic [NUM_SPINS-1:0] osc_s;
    logic                 ref_s;
    logic [NUM_SPINS-1:0] mism;

    for (genvar i = 0; i < NUM_SPINS; i++) begin : g_osc_sync
        spin_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (axi_rstn),
            .d     (osc_in[i]),
            .q     (osc_s[i])
        );
    end

    spin_sync #(.STAGES(SYNC_STAGES)) u_ref_sync (
        .clk   (clk),
        .rst_n (axi_rstn),
        .d     (ref_in),
        .q     (ref_s)
    );

    always_comb begin
        mism = osc_s ^ {NUM_SPINS{ref_s}};
    end

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] win_q, win_d;
    logic [CNT_WIDTH-1:0] samp_q, samp_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_SPINS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_SPINS];
    logic [NUM_SPINS-1:0] spins_q, spins_d;
    logic                 done_q, done_d;

    // NOTE: every variable gets its hold value before the case statement, so
    // no path through the FSM leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        samp_d  = samp_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        spins_d = spins_q;
        done_d  = done_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    win_d   = bus.window;
                    samp_d  = '0;
                    flush_d = '0;
                    for (int i = 0; i < NUM_SPINS; i++) begin
                        cnt_d[i] = '0;
                    end
                    done_d  = 1'b0;
                    state_d = ST_FLUSH;
                end
            end

            // Drain the synchronisers so pre-start tap values are never counted.
            ST_FLUSH: begin
                if (flush_q == FLUSH_W'(SYNC_STAGES - 1)) begin
                    state_d = (win_q == '0) ? ST_DONE : ST_SAMPLE;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end

            // Terminal compare against win_q-1 keeps a full-scale window from wrapping.
            ST_SAMPLE: begin
                for (int i = 0; i < NUM_SPINS; i++) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(mism[i]);
                end
                if (samp_q == (win_q - 1'b1)) begin
                    state_d = ST_DONE;
                end else begin
                    samp_d = samp_q + 1'b1;
                end
            end

            ST_DONE: begin
                // Strict majority at CNT_WIDTH+1 bits; a tie resolves to 0.
                for (int i = 0; i < NUM_SPINS; i++) begin
                    spins_d[i] = (win_q != '0) &&
                                 ({cnt_q[i], 1'b0} > {1'b0, win_q});
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the counter array is an explicit reset target because an aborted
    // measurement must leave no partial counts behind.
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            samp_q  <= '0;
            flush_q <= '0;
            for (int i = 0; i < NUM_SPINS; i++) begin
                cnt_q[i] <= '0;
            end
            spins_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            samp_q  <= samp_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            spins_q <= spins_d;
            done_q  <= done_d;
        end
    end

    logic [RDATA_WIDTH-1:0] rdata_c;

    always_comb begin
        rdata_c                  = '0;
        rdata_c[NUM_SPINS-1:0]   = spins_q;
        rdata_c[BUSY_BIT]        = (state_q != ST_IDLE);
        rdata_c[DONE_BIT]        = done_q;
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = done_q;
    assign bus.spins = spins_q;
    assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_spin_readout.sv
// Scoreboard bench for spin_readout: drives per-sample mismatch masks, predicts
// spins and completion latency, and checks them when done rises.
module tb_spin_readout;
    import spin_readout_pkg::*;

    localparam int NS = 8;
    localparam int CW = 16;
    localparam int SS = 2;
    localparam int WAIT_LIMIT = 2000;

    logic          clk = 1'b0;
    logic          axi_rstn;
    logic [NS-1:0] osc_in;
    logic          ref_in;

    spin_readout_if #(.NUM_SPINS(NS), .CNT_WIDTH(CW)) bus ();

    spin_readout #(.NUM_SPINS(NS), .CNT_WIDTH(CW), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .axi_rstn (axi_rstn),
        .osc_in   (osc_in),
        .ref_in   (ref_in),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [NS-1:0] spins;
        int unsigned   lat;
    } exp_t;

    exp_t          sb[$];
    logic [NS-1:0] last_spins = '0;

    // Per-sample mismatch mask: bit i set means osc_in[i] differs from ref_in.
    function automatic logic [NS-1:0] mism(input int mode, input int j);
        logic [NS-1:0] m;
        m = '0;
        case (mode)
            0: m = 8'hF0;
            1: m = 8'hA5;
            2: begin
                m[0] = (j < 5);
                m[1] = (j < 6);
            end
            3: m = NS'($urandom);
            default: m = '0;
        endcase
        return m;
    endfunction

    // The tap value driven in the cycle after acceptance edge A+j is sample j+1:
    // the flush delay exactly matches the synchroniser depth.
    task automatic measure(input logic [CW-1:0] w, input int mode, input int restart_at);
        logic [NS-1:0] mask;
        logic [NS-1:0] sp;
        int            cnt[NS];
        exp_t          e;
        exp_t          got_e;
        int unsigned   a_edge;
        int            waited;

        foreach (cnt[i]) cnt[i] = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.window = w;
        osc_in     = NS'($urandom);
        ref_in     = 1'($urandom);
        @(posedge clk);
        #1;
        a_edge     = cyc;
        bus.start  = 1'b0;
        bus.window = CW'($urandom);

        for (int j = 0; j < int'(w); j++) begin
            mask   = mism(mode, j);
            ref_in = 1'($urandom);
            osc_in = {NS{ref_in}} ^ mask;
            for (int i = 0; i < NS; i++) cnt[i] += int'(mask[i]);
            if (j == restart_at) begin
                bus.start  = 1'b1;
                bus.window = 16'd3;
            end else begin
                bus.start  = 1'b0;
            end
            if (j == 1) begin
                check("busy_during", 32'(bus.busy), 32'd1);
                check("done_cleared", 32'(bus.done), 32'd0);
                check("spins_retained", 32'(bus.spins), 32'(last_spins));
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;

        for (int i = 0; i < NS; i++) sp[i] = (2 * cnt[i] > int'(w));
        e.spins = sp;
        e.lat   = 1 + SS + int'(w) + 1;
        sb.push_back(e);

        waited = 0;
        while (bus.done !== 1'b1 && waited < WAIT_LIMIT) begin
            @(posedge clk);
            #1;
            waited++;
        end
        got_e = sb.pop_front();
        if (bus.done !== 1'b1) begin
            check("done_timeout", 32'(bus.done), 32'd1);
        end else begin
            // Latency measured from the cycle in which start was sampled high.
            check("latency", cyc - (a_edge - 1), got_e.lat);
            check("spins", 32'(bus.spins), 32'(got_e.spins));
            check("busy_after", 32'(bus.busy), 32'd0);
            check("rdata", bus.rdata, {1'b1, 1'b0, {(30 - NS){1'b0}}, got_e.spins});
            last_spins = got_e.spins;
        end
    endtask

    task automatic reset_mid_sample();
        @(negedge clk);
        bus.start  = 1'b1;
        bus.window = 16'd100;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int j = 0; j < 52; j++) begin
            ref_in = 1'($urandom);
            osc_in = {NS{ref_in}} ^ 8'h3C;
            @(posedge clk);
            #1;
        end
        check("busy_pre_reset", 32'(bus.busy), 32'd1);
        #2;
        axi_rstn = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_spins", 32'(bus.spins), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        last_spins = '0;
        @(negedge clk);
        @(negedge clk);
        axi_rstn = 1'b1;
    endtask

    // start held high: ignored during busy and in the DONE cycle, taken right after.
    task automatic held_start();
        int unsigned a_edge;
        int          waited;
        @(negedge clk);
        osc_in     = '0;
        ref_in     = 1'b0;
        bus.start  = 1'b1;
        bus.window = 16'd2;
        @(posedge clk);
        #1;
        a_edge = cyc;
        waited = 0;
        while (bus.done !== 1'b1 && waited < WAIT_LIMIT) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("held_latency", cyc - (a_edge - 1), 32'(1 + SS + 2 + 1));
        check("held_idle_rdata", bus.rdata, 32'h8000_0000);
        @(posedge clk);
        #1;
        check("held_reaccept_busy", 32'(bus.busy), 32'd1);
        check("held_reaccept_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        waited = 0;
        while (bus.done !== 1'b1 && waited < WAIT_LIMIT) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("held_second_done", 32'(bus.done), 32'd1);
        check("held_second_spins", 32'(bus.spins), 32'd0);
        last_spins = '0;
    endtask

    initial begin
        axi_rstn   = 1'b0;
        bus.start  = 1'b0;
        bus.window = '0;
        osc_in     = '0;
        ref_in     = 1'b0;
        #1;
        check("reset_rdata", bus.rdata, 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_spins", 32'(bus.spins), 32'd0);
        repeat (3) @(negedge clk);
        axi_rstn = 1'b1;

        measure(16'd64, 0, -1);
        check("phase_rdata", bus.rdata, 32'h8000_00F0);
        measure(16'd10, 2, -1);
        measure(16'd0, 3, -1);
        measure(16'd20, 3, 5);
        measure(16'd40, 1, -1);
        measure(16'd16, 4, -1);
        measure(16'd40, 1, -1);
        reset_mid_sample();
        measure(16'd300, 3, -1);
        measure(16'd1, 3, -1);
        held_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spin_readout.md
Name: spin_readout

Overview:
- Downstream consumer of the shorted ring-oscillator cell outputs (sout/dout taps) in the Ising array.
- Samples each oscillator tap against a reference oscillator in the clk domain and counts phase mismatches over a programmable window.
- Majority-votes each count into a final spin bit, then exposes the spin vector and status on a 32-bit rdata word for the AXI read path.

Parameters:
- NUM_SPINS, 8, number of oscillator taps observed. Legal range 1..30.
- CNT_WIDTH, 16, width of the window length and of the per-spin mismatch counters.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser. Minimum 2.

Ports:
- clk  input  1  system/AXI clock.
- axi_rstn  input  1  asynchronous, active-low reset.
- osc_in  input  NUM_SPINS  raw oscillator taps, asynchronous to clk.
- ref_in  input  1  reference oscillator tap, asynchronous to clk.
- start  input  1  single-cycle request to begin a measurement.
- window  input  CNT_WIDTH  number of samples per measurement. Captured on an accepted start.
- busy  output  1  high from the cycle after an accepted start until DONE is reached.
- done  output  1  sticky completion flag. Cleared by the next accepted start.
- spins  output  NUM_SPINS  latest measured spin vector.
- rdata  output  32  {done, busy, zero-pad, spins}: bit31=done, bit30=busy, bits[NUM_SPINS-1:0]=spins, all other bits 0.

Behaviour:
- Reset (axi_rstn low, asynchronous): FSM=IDLE; all synchroniser flops, counters and captured window = 0; busy=0, done=0, spins=0, rdata=0. Reset asserted mid-measurement aborts it immediately. No partial result is kept.
- Synchronisers: osc_in and ref_in each pass through SYNC_STAGES flops. Let osc_s/ref_s be the synchronised values. Per-spin mismatch term m[i] = osc_s[i] XOR ref_s.
- FSM states:
  - IDLE: start=1 is accepted. Capture window into win_q, clear all counters, clear done, go to FLUSH. busy rises the next cycle.
  - FLUSH: wait SYNC_STAGES cycles (flush counter) so no pre-start sample is counted, then go to SAMPLE. If win_q==0, go straight from FLUSH to DONE instead.
  - SAMPLE: each cycle, every counter cnt[i] increments by m[i] and the sample counter increments. After exactly win_q sample cycles, go to DONE.
  - DONE (one cycle): spins[i] = 1 iff 2*cnt[i] > win_q, computed at CNT_WIDTH+1 bits with no overflow. A tie gives 0. If win_q==0, all spins=0. Set done=1, drop busy, return to IDLE.
- start while busy (FLUSH/SAMPLE/DONE) is ignored. It is not queued.
- start in the same cycle DONE completes is ignored. It is accepted the next cycle if still high.
- Counters cannot exceed win_q, so no saturation logic is needed. The sample counter compares against win_q; with win_q = 2^CNT_WIDTH-1 it must terminate without wrap.
- spins and done hold their values until the next measurement's DONE or a reset. spins is NOT cleared on start.
- Latency: start accepted at cycle T → done high at T + 1 + SYNC_STAGES + win_q + 1.
- rdata is combinational from registered state. No read side effects.

Decomposition:
- Shared package/defines: FSM state encoding (IDLE, FLUSH, SAMPLE, DONE, 2 bits), the rdata bit positions (DONE_BIT=31, BUSY_BIT=30), and the NUM_SPINS<=30 limit check.
- One natural sub-module: spin_sync, a parameterised SYNC_STAGES-deep single-bit synchroniser. Instantiate it NUM_SPINS+1 times. Mark it dont_touch / ASYNC_REG for synthesis; plain flops in SIM.

Test Plan:
- Reset mid-SAMPLE:
  - Stimulus: start with window=100; assert axi_rstn low at sample 50.
  - Required response: busy=0, done=0, spins=0 and rdata=0 in the same cycle, asynchronously.
- In-phase vs anti-phase:
  - Stimulus: NUM_SPINS=8, window=64; osc_in[3:0] driven identical to ref_in, osc_in[7:4] driven as ~ref_in.
  - Required response: spins=8'hF0, done=1, rdata=32'h8000_00F0; done rises exactly 1+2+64+1 cycles after start.
- Tie and majority:
  - Stimulus: window=10; spin0 mismatches 5 samples, spin1 mismatches 6 samples.
  - Required response: spins[0]=0, spins[1]=1.
- window=0:
  - Stimulus: start with window=0.
  - Required response: done=1 at T+1+SYNC_STAGES+1, spins=0.
- start during busy:
  - Stimulus: window=20; a second start at sample 5 with window=3.
  - Required response: ignored. Completion occurs at the window=20 timing, and win_q stays 20.
- Result retention:
  - Stimulus: after a result of spins=8'hA5, issue a new start.
  - Required response: spins stays 8'hA5 and done=0 while busy=1, until the new DONE.
